// File: rtl/hack_ps2_keyboard.sv
// PS/2 Set-2 receiver producing the Hack keyboard register value.
// Optional parity enforcement: define HACK_KBD_PARITY_CHECK_EN.
module hack_ps2_keyboard #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key_code,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam logic [31:0] TMAX = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic       clk_s1_q, clk_s2_q, clk_prev_q;
  logic       dat_s1_q, dat_s2_q;
  logic       fall_q, bit_q;

  state_t      state_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [31:0] cnt_q;
  logic [7:0]  byte_q;
  logic        byte_vld_q;
  logic        frame_err_q;
`ifdef HACK_KBD_PARITY_CHECK_EN
  logic        par_q;
`endif

  logic        ext_q, brk_q;
  logic [7:0]  key_q;
  logic        strobe_q;
  logic [7:0]  code_d;

  // Synchronize both lines and register the ps2_clk falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      fall_q     <= 1'b0;
      bit_q      <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      fall_q     <= clk_prev_q & ~clk_s2_q;
      bit_q      <= dat_s2_q;
    end
  end

  // Frame FSM with idle timeout; delivers one byte per good frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef HACK_KBD_PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall_q) begin
        cnt_q <= '0;
        unique case (state_q)
          S_IDLE: begin
            if (!bit_q) begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end
          end
          S_DATA: begin
            shift_q <= {bit_q, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
`ifdef HACK_KBD_PARITY_CHECK_EN
            par_q   <= bit_q;
`endif
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (!bit_q) begin
              frame_err_q <= 1'b1;
`ifdef HACK_KBD_PARITY_CHECK_EN
            end else if (!(^{shift_q, par_q})) begin
              frame_err_q <= 1'b1;
`endif
            end else begin
              byte_q     <= shift_q;
              byte_vld_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        if (cnt_q == TMAX) begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          frame_err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Set-2 scan code to Hack key code; 0 means unmapped.
  always_comb begin
    code_d = 8'd0;
    if (ext_q) begin
      unique case (byte_q)
        8'h6B: code_d = 8'd130;
        8'h75: code_d = 8'd131;
        8'h74: code_d = 8'd132;
        8'h72: code_d = 8'd133;
        8'h6C: code_d = 8'd134;
        8'h69: code_d = 8'd135;
        8'h7D: code_d = 8'd136;
        8'h7A: code_d = 8'd137;
        8'h70: code_d = 8'd138;
        8'h71: code_d = 8'd139;
        default: code_d = 8'd0;
      endcase
    end else begin
      unique case (byte_q)
        8'h1C: code_d = 8'd65;
        8'h32: code_d = 8'd66;
        8'h21: code_d = 8'd67;
        8'h23: code_d = 8'd68;
        8'h24: code_d = 8'd69;
        8'h2B: code_d = 8'd70;
        8'h34: code_d = 8'd71;
        8'h33: code_d = 8'd72;
        8'h43: code_d = 8'd73;
        8'h3B: code_d = 8'd74;
        8'h42: code_d = 8'd75;
        8'h4B: code_d = 8'd76;
        8'h3A: code_d = 8'd77;
        8'h31: code_d = 8'd78;
        8'h44: code_d = 8'd79;
        8'h4D: code_d = 8'd80;
        8'h15: code_d = 8'd81;
        8'h2D: code_d = 8'd82;
        8'h1B: code_d = 8'd83;
        8'h2C: code_d = 8'd84;
        8'h3C: code_d = 8'd85;
        8'h2A: code_d = 8'd86;
        8'h1D: code_d = 8'd87;
        8'h22: code_d = 8'd88;
        8'h35: code_d = 8'd89;
        8'h1A: code_d = 8'd90;
        8'h45: code_d = 8'd48;
        8'h16: code_d = 8'd49;
        8'h1E: code_d = 8'd50;
        8'h26: code_d = 8'd51;
        8'h25: code_d = 8'd52;
        8'h2E: code_d = 8'd53;
        8'h36: code_d = 8'd54;
        8'h3D: code_d = 8'd55;
        8'h3E: code_d = 8'd56;
        8'h46: code_d = 8'd57;
        8'h29: code_d = 8'd32;
        8'h5A: code_d = 8'd128;
        8'h66: code_d = 8'd129;
        8'h76: code_d = 8'd140;
        default: code_d = 8'd0;
      endcase
    end
  end

  // Prefix tracking and make/break update of the held key.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      key_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (byte_vld_q) begin
        if (byte_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (code_d != 8'd0) begin
            if (brk_q) begin
              if (code_d == key_q) begin
                key_q    <= 8'd0;
                strobe_q <= 1'b1;
              end
            end else if (code_d != key_q) begin
              key_q    <= code_d;
              strobe_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign key_code   = {8'd0, key_q};
  assign key_strobe = strobe_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_hack_ps2_keyboard.sv
// Scoreboard bench for hack_ps2_keyboard: directed PS/2 frames,
// expected strobe/error events queued and popped by a monitor.
module tb_hack_ps2_keyboard;

  localparam int TO   = 400;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] key_code;
  logic        key_strobe;
  logic        frame_err;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          err;
    logic [15:0] code;
  } ev_t;

  ev_t exp_q[$];

  hack_ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_code   (key_code),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic exp_key(input logic [15:0] c);
    ev_t e;
    e.err  = 1'b0;
    e.code = c;
    exp_q.push_back(e);
  endtask

  task automatic exp_err();
    ev_t e;
    e.err  = 1'b1;
    e.code = 16'd0;
    exp_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b,
                      input bit bad_par,
                      input bit stop);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (3 * HALF) @(posedge clk);
  endtask

  task automatic sendb(input logic [7:0] b);
    send(b, 1'b0, 1'b1);
  endtask

  task automatic partial(input logic [7:0] b,
                         input int nb);
    ps2_bit(1'b0);
    for (int i = 0; i < nb; i++) ps2_bit(b[i]);
    ps2_data = 1'b1;
  endtask

  // Monitor: every strobe or error must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (key_strobe && frame_err) begin
        n_chk++;
        n_fail++;
        $display("FAIL overlap: strobe and frame_err both 1");
      end
      if (key_strobe || frame_err) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected: strobe=%0b err=%0b key=%0d",
                   key_strobe, frame_err, key_code);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event_kind", {15'd0, frame_err},
              {15'd0, e.err});
          if (!e.err) chk("strobe_key", key_code, e.code);
        end
      end
    end
  end

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_key", key_code, 16'd0);
    chk("rst_strobe", {15'd0, key_strobe}, 16'd0);
    chk("rst_err", {15'd0, frame_err}, 16'd0);
    @(posedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);

    // A make, A break
    exp_key(16'd65);
    sendb(8'h1C);
    chk("a_make", key_code, 16'd65);
    exp_key(16'd0);
    sendb(8'hF0);
    sendb(8'h1C);
    chk("a_break", key_code, 16'd0);

    // Up arrow make, repeat, break
    exp_key(16'd131);
    sendb(8'hE0);
    sendb(8'h75);
    sendb(8'hE0);
    sendb(8'h75);
    chk("up_rep", key_code, 16'd131);
    exp_key(16'd0);
    sendb(8'hE0);
    sendb(8'hF0);
    sendb(8'h75);
    chk("up_break", key_code, 16'd0);

    // A, B, then A break leaves B
    exp_key(16'd65);
    sendb(8'h1C);
    exp_key(16'd66);
    sendb(8'h32);
    sendb(8'hF0);
    sendb(8'h1C);
    chk("b_held", key_code, 16'd66);
    exp_key(16'd0);
    sendb(8'hF0);
    sendb(8'h32);
    chk("b_break", key_code, 16'd0);

    // Wrong parity on A
`ifdef HACK_KBD_PARITY_CHECK_EN
    exp_err();
    send(8'h1C, 1'b1, 1'b1);
    chk("par_bad", key_code, 16'd0);
`else
    exp_key(16'd65);
    send(8'h1C, 1'b1, 1'b1);
    chk("par_ign", key_code, 16'd65);
    exp_key(16'd0);
    sendb(8'hF0);
    sendb(8'h1C);
`endif

    // Stop bit 0 on space
    exp_err();
    send(8'h29, 1'b0, 1'b0);
    chk("stop_bad", key_code, 16'd0);

    // Partial frame then timeout
    exp_err();
    partial(8'h45, 3);
    repeat (TO + 50) @(posedge clk);
    exp_key(16'd48);
    sendb(8'h45);
    chk("after_to", key_code, 16'd48);
    exp_key(16'd0);
    sendb(8'hF0);
    sendb(8'h45);

    // Reset mid-frame drops frame and pending break
    sendb(8'hF0);
    partial(8'hF0, 5);
    @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_key", key_code, 16'd0);
    chk("mid_rst_err", {15'd0, frame_err}, 16'd0);
    @(posedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    exp_key(16'd128);
    sendb(8'h5A);
    chk("enter", key_code, 16'd128);

    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_ps2_keyboard.md
# hack_ps2_keyboard

PS/2 Set-2 keyboard receiver that turns raw ps2_clk/ps2_data traffic into the 16-bit Hack key code held by the keyboard register at address 24576. Sits directly upstream of the memory map's keyboard register: `key_code` is the value to store, and `key_strobe` marks each change. Handles frame reception, parity, the E0 extended prefix and the F0 break prefix, so the register reads 0 whenever no mapped key is held.

## Interface
- `TIMEOUT_CYCLES`, default 100000: `clk` cycles without a ps2_clk falling edge before a partial frame is abandoned.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `ps2_clk`  input  1  raw PS/2 clock, asynchronous, idle high.
- `ps2_data`  input  1  raw PS/2 data, asynchronous, idle high.
- `key_code`  output  16  current Hack key code, 0 when no key is held; bits 15:8 are always 0.
- `key_strobe`  output  1  one-cycle pulse, asserted in the same cycle `key_code` takes a new value.
- `frame_err`  output  1  one-cycle pulse when a frame is discarded (stop bit, parity or timeout).

## Operation
- Both PS/2 inputs pass through a 2-FF synchronizer. A falling edge is registered sync value 1 followed by sync value 0, and every bit is sampled on that detection cycle.
- Frame FSM:
  - IDLE to DATA on a falling edge with data=0 (start bit). A falling edge with data=1 in IDLE is ignored with no error.
  - DATA samples 8 bits LSB-first, using a 3-bit index, then goes to PARITY.
  - PARITY samples the parity bit, then goes to STOP.
  - STOP samples the stop bit, then returns to IDLE.
    - Stop=0 discards the byte and pulses `frame_err`.
    - Stop=1 with good parity (odd parity over 8 data bits plus the parity bit) delivers the byte.
- Timeout:
  - An idle counter clears on every falling edge and counts only outside IDLE.
  - Reaching `TIMEOUT_CYCLES`-1 forces IDLE and pulses `frame_err`.
- Decoder:
  - Byte E0 sets `ext`. Byte F0 sets `brk`. Any other byte is a code byte that is looked up, then clears both flags.
- Keymap, no prefix:
  - Letters map to upper case: 1C=65(A), 32=66, 21=67, 23=68, 24=69, 2B=70, 34=71, 33=72, 43=73, 3B=74, 42=75, 4B=76, 3A=77, 31=78, 44=79, 4D=80, 15=81, 2D=82, 1B=83, 2C=84, 3C=85, 2A=86, 1D=87, 22=88, 35=89, 1A=90.
  - Digits: 45=48, 16=49, 1E=50, 26=51, 25=52, 2E=53, 36=54, 3D=55, 3E=56, 46=57.
  - Others: 29=32 (space), 5A=128 (enter), 66=129 (backspace), 76=140 (esc).
- Keymap, with E0 prefix: 6B=130, 75=131, 74=132, 72=133, 6C=134, 69=135, 7D=136, 7A=137, 70=138, 71=139.
- Anything else maps to 0, meaning unmapped. Unmapped codes leave all outputs unchanged.
- Update rules for a mapped code c:
  - Make with c != `key_code`: `key_code`=c and strobe.
  - Make with c == `key_code` (typematic repeat): no change, no strobe.
  - Break with c == `key_code`: `key_code`=0 and strobe.
  - Break of any other key: no change.

## Timing
- Reset values:
  - Outputs: `key_code`=0, `key_strobe`=0, `frame_err`=0.
  - Internal: FSM=IDLE, `ext`=`brk`=0, counter=0, synchronizers=1.
- Reset mid-frame drops the partial frame and any pending prefix. The first complete frame after reset decodes normally.
- Latency: the stop-bit falling edge is detected in cycle N, the byte is registered valid in N+1, and `key_code`/`key_strobe` update in N+2. `frame_err` pulses in N+1.
- A ps2_clk falling edge to detection takes 3 `clk` cycles (2 synchronizer stages plus the edge register).
- `key_strobe` and `frame_err` never assert in the same cycle, and each is exactly one cycle wide.
- A timeout in the same cycle as a falling edge: the edge wins and the counter clears.

## Configuration
- `HACK_KBD_PARITY_CHECK_EN` defined: a parity mismatch discards the byte, pulses `frame_err`, and leaves `ext`/`brk` unchanged.
- Undefined: the parity bit is sampled but ignored, and only the stop bit and timeout can cause `frame_err`.

## Test plan
- Frame 1C (A make), then F0 1C: `key_code`=65 with strobe at N+2, then `key_code`=0 with strobe; `frame_err` stays 0.
- E0 75 (up make), E0 75 repeated, then E0 F0 75: `key_code`=131 with one strobe only, then 0 with strobe.
- A make, then 32 (B make), then F0 1C (A break): `key_code`=65, then 66; the A break causes no change and `key_code` stays 66.
- Frame 1C with a wrong parity bit: with the macro, `frame_err` pulses and `key_code`=0; without it, `key_code`=65.
- Stop bit=0 on frame 29: `frame_err` pulses and `key_code`=0. Then 4 bits sent and the bus held idle for `TIMEOUT_CYCLES`: `frame_err` pulses, and the next frame 45 gives `key_code`=48.
- Reset asserted after 5 data bits of F0, then frame 5A sent: `key_code`=128 (make, not break).
